// File: rtl/ble_pkt_deframer_if.sv
// Bit-stream and packet-event bundle between the bit slicer and the BLE deframer.
// master drives the sliced bits; slave is the deframer producing packet events.
interface ble_pkt_deframer_if;
    logic       en;
    logic       bit_in;
    logic       bit_valid;
    logic [5:0] channel;
    logic       pkt_start;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       pkt_end;
    logic       crc_ok;
    logic       len_err;
    logic       busy;

    modport master (
        output en, bit_in, bit_valid, channel,
        input  pkt_start, byte_data, byte_valid, pkt_end, crc_ok, len_err, busy
    );

    modport slave (
        input  en, bit_in, bit_valid, channel,
        output pkt_start, byte_data, byte_valid, pkt_end, crc_ok, len_err, busy
    );
endinterface

// File: rtl/ble_pkt_deframer.sv
// Bit-serial BLE link-layer deframer: tolerant access-address correlation,
// dewhitening, byte assembly, length limit and CRC-24 verdict.
module ble_pkt_deframer #(
    parameter logic [31:0] ACCESS_ADDR   = 32'h8E89BED6,
    parameter int unsigned AA_MAX_ERR    = 1,
    parameter int unsigned MAX_PDU_BYTES = 39,
    parameter bit          WHITEN_EN     = 1'b1,
    parameter logic [23:0] CRC_INIT      = 24'h555555
) (
    input logic               clk,
    input logic               rst,
    ble_pkt_deframer_if.slave bus
);
    localparam logic [5:0]  AA_TOL   = 6'(AA_MAX_ERR);
    localparam logic [7:0]  LEN_MAX  = 8'(MAX_PDU_BYTES);
    localparam logic [23:0] CRC_POLY = 24'h00065B;

    typedef enum logic [1:0] {SEARCH, HEADER, PAYLOAD, CRC} state_t;

    state_t      state_reg;
    logic [31:0] sr_reg;
    logic [6:0]  w_reg;
    logic [23:0] crc_reg;
    logic [7:0]  byte_reg;
    logic [7:0]  len_reg;
    logic [10:0] bit_cnt_reg;
    logic        err_reg;
    logic        pkt_start_reg;
    logic        byte_valid_reg;
    logic [7:0]  byte_data_reg;
    logic        pkt_end_reg;
    logic        crc_ok_reg;
    logic        len_err_reg;

    logic [31:0] sr_next;
    logic [31:0] aa_diff;
    logic [5:0]  aa_errs;
    logic        aa_match;
    logic [6:0]  w_next;
    logic [6:0]  w_seed;
    logic        d;
    logic [23:0] crc_next;
    logic [7:0]  byte_next;
    logic        byte_done;
    logic        payload_last;
    logic        crc_bit_bad;

    assign sr_next = {bus.bit_in, sr_reg[31:1]};
    assign aa_diff = sr_next ^ ACCESS_ADDR;

    always_comb begin
        aa_errs = '0;
        for (int i = 0; i < 32; i++) aa_errs = aa_errs + {5'd0, aa_diff[i]};
    end
    assign aa_match = (aa_errs <= AA_TOL);

    // Whitening LFSR x^7+x^4+1; seed is 1 followed by the channel index MSB first.
    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_white
            if (gi == 0) begin : g_head
                assign w_seed[gi] = 1'b1;
                assign w_next[gi] = w_reg[6];
            end else begin : g_body
                assign w_seed[gi] = bus.channel[6 - gi];
                if (gi == 4) begin : g_tap
                    assign w_next[gi] = w_reg[3] ^ w_reg[6];
                end else begin : g_shift
                    assign w_next[gi] = w_reg[gi - 1];
                end
            end
        end
    endgenerate

    assign d            = bus.bit_in ^ (WHITEN_EN ? w_reg[6] : 1'b0);
    assign crc_next     = {crc_reg[22:0], 1'b0} ^ ((crc_reg[23] ^ d) ? CRC_POLY : 24'd0);
    assign byte_next    = {d, byte_reg[7:1]};
    assign byte_done    = (bit_cnt_reg[2:0] == 3'd7);
    assign payload_last = (bit_cnt_reg == ({len_reg, 3'b000} - 11'd1));
    assign crc_bit_bad  = d ^ crc_reg[23];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= SEARCH;
            sr_reg         <= '0;
            w_reg          <= '0;
            crc_reg        <= '0;
            byte_reg       <= '0;
            len_reg        <= '0;
            bit_cnt_reg    <= '0;
            err_reg        <= 1'b0;
            pkt_start_reg  <= 1'b0;
            byte_valid_reg <= 1'b0;
            byte_data_reg  <= '0;
            pkt_end_reg    <= 1'b0;
            crc_ok_reg     <= 1'b0;
            len_err_reg    <= 1'b0;
        end else begin
            pkt_start_reg  <= 1'b0;
            byte_valid_reg <= 1'b0;
            pkt_end_reg    <= 1'b0;
            crc_ok_reg     <= 1'b0;
            len_err_reg    <= 1'b0;
            if (!bus.en) begin
                state_reg <= SEARCH;
                sr_reg    <= '0;
            end else if (bus.bit_valid) begin
                case (state_reg)
                    SEARCH: begin
                        sr_reg <= sr_next;
                        if (aa_match) begin
                            pkt_start_reg <= 1'b1;
                            w_reg         <= w_seed;
                            crc_reg       <= CRC_INIT;
                            bit_cnt_reg   <= '0;
                            err_reg       <= 1'b0;
                            state_reg     <= HEADER;
                        end
                    end
                    HEADER: begin
                        w_reg       <= w_next;
                        crc_reg     <= crc_next;
                        byte_reg    <= byte_next;
                        bit_cnt_reg <= bit_cnt_reg + 11'd1;
                        if (byte_done) begin
                            byte_valid_reg <= 1'b1;
                            byte_data_reg  <= byte_next;
                        end
                        if (bit_cnt_reg == 11'd15) begin
                            len_reg     <= byte_next;
                            bit_cnt_reg <= '0;
                            if (byte_next > LEN_MAX) begin
                                pkt_end_reg <= 1'b1;
                                len_err_reg <= 1'b1;
                                sr_reg      <= '0;
                                state_reg   <= SEARCH;
                            end else if (byte_next == 8'd0) begin
                                state_reg <= CRC;
                            end else begin
                                state_reg <= PAYLOAD;
                            end
                        end
                    end
                    PAYLOAD: begin
                        w_reg       <= w_next;
                        crc_reg     <= crc_next;
                        byte_reg    <= byte_next;
                        bit_cnt_reg <= bit_cnt_reg + 11'd1;
                        if (byte_done) begin
                            byte_valid_reg <= 1'b1;
                            byte_data_reg  <= byte_next;
                        end
                        if (payload_last) begin
                            bit_cnt_reg <= '0;
                            state_reg   <= CRC;
                        end
                    end
                    CRC: begin
                        // Received CRC bits are compared against the running remainder, MSB first.
                        w_reg       <= w_next;
                        crc_reg     <= {crc_reg[22:0], 1'b0};
                        err_reg     <= err_reg | crc_bit_bad;
                        bit_cnt_reg <= bit_cnt_reg + 11'd1;
                        if (bit_cnt_reg == 11'd23) begin
                            pkt_end_reg <= 1'b1;
                            crc_ok_reg  <= !(err_reg | crc_bit_bad);
                            sr_reg      <= '0;
                            state_reg   <= SEARCH;
                        end
                    end
                    default: state_reg <= SEARCH;
                endcase
            end
        end
    end

    assign bus.pkt_start  = pkt_start_reg;
    assign bus.byte_data  = byte_data_reg;
    assign bus.byte_valid = byte_valid_reg;
    assign bus.pkt_end    = pkt_end_reg;
    assign bus.crc_ok     = crc_ok_reg;
    assign bus.len_err    = len_err_reg;
    assign bus.busy       = (state_reg != SEARCH);
endmodule

// File: doc/ble_pkt_deframer.md
# ble_pkt_deframer

Parametrised BLE link-layer deframer that sits between the GFSK bit slicer and the byte-level packet logic inside `tt_um_BLE_RX`. It correlates the incoming bit stream against a configurable access address with a programmable bit-error tolerance, then dewhitens the PDU and checks CRC-24. It delivers header and payload bytes with start and end strobes and a CRC verdict. It generalises the fixed single-AA, zero-tolerance receiver path to arbitrary AA, error budget, PDU length limit and optional whitening.

## Interface
- `ACCESS_ADDR`, 32'h8E89BED6, access address to match; transmitted LSB first.
- `AA_MAX_ERR`, 1, maximum Hamming distance accepted on the 32-bit AA; range 0–4.
- `MAX_PDU_BYTES`, 39, largest accepted payload length in bytes; range 1–255.
- `WHITEN_EN`, 1, enables dewhitening when 1; when 0 the whitening bit is forced to 0.
- `CRC_INIT`, 24'h555555, CRC LFSR seed.
- `clk` input 1: the single clock. Everything is rising-edge.
- `rst` input 1: synchronous reset, active-high. Highest priority.
- `en` input 1: receiver enable. When 0 the FSM goes to SEARCH on the next edge, the AA shift register is cleared, and no `pkt_end` is issued.
- `bit_in` input 1: sliced air bit.
- `bit_valid` input 1: qualifies `bit_in`. At most one bit is consumed per asserted cycle.
- `channel` input 6: RF channel index, 0–39. Sampled on the cycle the AA matches.
- `pkt_start` output 1: 1-cycle pulse on AA match.
- `byte_data` output 8: dewhitened PDU byte, header included. LSB is the first received bit.
- `byte_valid` output 1: 1-cycle pulse qualifying `byte_data`.
- `pkt_end` output 1: 1-cycle pulse marking the end of a packet.
- `crc_ok` output 1: valid while `pkt_end`=1; 1 means all 24 CRC bits matched.
- `len_err` output 1: valid while `pkt_end`=1; 1 means the length field exceeded `MAX_PDU_BYTES`.
- `busy` output 1: high in every state other than SEARCH.

## Operation
- All outputs reset to 0. State resets to SEARCH. The AA shift register resets to 0.
- State and datapath registers advance only on cycles with `bit_valid`=1 (and `en`=1). Strobe outputs are cleared every cycle they are not set.

**FSM states: SEARCH, HEADER, PAYLOAD, CRC.**

**SEARCH**
- Shift register `sr` updates as `sr <= {bit_in, sr[31:1]}`.
- Match condition: `popcount(next_sr ^ ACCESS_ADDR) <= AA_MAX_ERR`.
- On a match:
  - pulse `pkt_start`;
  - latch `channel`;
  - load whitening LFSR `w[0..6]` with `w[0]=1`, `w[1]=ch[5]` … `w[6]=ch[0]`;
  - load CRC with `CRC_INIT`;
  - clear the bit and byte counters;
  - go to HEADER.

**Dewhitening (per consumed bit, HEADER/PAYLOAD/CRC)**
- `wb = WHITEN_EN ? w[6] : 0`; `d = bit_in ^ wb`.
- LFSR update: `w[0]<=w[6]`, `w[4]<=w[3]^w[6]`, every other `w[i]<=w[i-1]`.

**CRC (HEADER and PAYLOAD bits)**
- `fb = crc[23]^d`.
- `crc <= {crc[22:0],1'b0} ^ (fb ? 24'h00065B : 0)`.

**Byte assembly**
- `d` shifts into the byte register MSB-first (`{d, b[7:1]}`).
- After the 8th bit: pulse `byte_valid` with the completed byte.

**HEADER**
- 16 bits, producing 2 bytes.
- Byte 1 is the length field L.
- If L > `MAX_PDU_BYTES`:
  - on the cycle after the 16th bit, pulse `pkt_end` with `len_err`=1 and `crc_ok`=0;
  - clear `sr`;
  - go to SEARCH.
- Else if L==0: go to CRC.
- Else: go to PAYLOAD.

**PAYLOAD**
- L·8 bits.
- Go to CRC after the last bit.

**CRC**
- 24 received bits.
- Each dewhitened `d` is compared with `crc[23]`, then the CRC register shifts left with a 0 fill (no feedback).
- Any mismatch sets a sticky error flag.
- After the 24th bit:
  - pulse `pkt_end` with `crc_ok = !err`;
  - clear `sr` so the tail cannot re-trigger;
  - go to SEARCH.

**Priority**
- `rst` wins over `en`; `en`=0 wins over `bit_valid`.
- A new AA match is not searched while `busy`=1.

## Timing
- Registered outputs; every strobe is 1 cycle wide.
- `pkt_start` appears 1 cycle after the `bit_valid` cycle carrying the 32nd AA bit.
- `byte_valid` appears 1 cycle after the cycle carrying bit 8 of each byte.
- `pkt_end` appears 1 cycle after the 24th CRC bit, or after the 16th header bit on `len_err`.
- Back-to-back `bit_valid` (every cycle) is supported at full rate; gaps of any length are allowed.
- `channel` changes after the match do not affect the packet in flight.
- `rst` or `en`=0 mid-packet: no further `byte_valid` or `pkt_end` for that packet; `busy` is 0 on the next cycle.

## Test plan
- **Advertising packet.** Channel 37, AA 8E89BED6, header 0x02/0x06, 6-byte payload 01 02 03 04 05 06, valid CRC (from the golden Python model), whitened, bit_valid every 4th cycle. Required: `pkt_start` ×1; 8 `byte_valid` carrying 02 06 01..06 in order; `pkt_end` with `crc_ok`=1, `len_err`=0.
- **AA tolerance.**
  - Same packet with AA bits 3 and 17 flipped, `AA_MAX_ERR`=1: no `pkt_start`.
  - Bit 3 flipped only: `pkt_start` plus full packet output.
  - `AA_MAX_ERR`=0 with 1 flip: no match.
- **CRC failure.** Same packet with payload byte 4 bit 0 flipped on air. Required: byte 4 reads 0x05; `pkt_end` with `crc_ok`=0.
- **Length limit.**
  - L=40 with `MAX_PDU_BYTES`=39: exactly 2 `byte_valid`, then `pkt_end` with `len_err`=1; `busy` low on the following cycle.
  - L=0 packet: 2 bytes, then `pkt_end` with `crc_ok`=1.
- **Abort.**
  - Drop `en` after payload byte 2: no `pkt_end`; `busy`=0 next cycle.
  - Re-enable and send a full packet: received correctly.
  - Repeat the sequence with `rst` in place of `en`: all outputs 0.
- **Whitening off and channel sweep.** `WHITEN_EN`=0 with unwhitened stimulus, and channels 0, 12 and 39: byte and CRC results match the model in every case.
